cpu_step_ctrl: RTL
==================

Name: cpu_step_ctrl

Overview:
- Execution controller for the board's single-cycle processor datapath.
- Gates the processor's clock enable from a debounced step button and a run switch, and halts on a program-counter breakpoint.
- Keeps an instruction counter for the LCD debug display.
- Sits between the board switches (SWI) and the processor core; its outputs drive the core enable and the LCD/LED status fields.

Parameters:
- NBITS_TOP, 8, width of pc, bp_addr and instr_count.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a step_btn level change is accepted (>=1).

Ports:
- clk_2  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- step_btn  input  1  raw single-step pushbutton (asynchronous, bouncy).
- run_sw  input  1  raw run switch level (asynchronous).
- bp_en  input  1  breakpoint enable.
- bp_addr  input  NBITS_TOP  breakpoint PC value.
- pc  input  NBITS_TOP  current program counter from the core.
- cpu_en  output  1  core clock enable; the core advances one instruction per cycle with cpu_en=1.
- halted  output  1  high in HALT or BREAK.
- state  output  2  FSM state: HALT=0, STEP=1, RUN=2, BREAK=3.
- instr_count  output  NBITS_TOP  number of cycles with cpu_en=1, modulo 2^NBITS_TOP.

Behaviour:
- Clock and reset: one clock, clk_2. Reset is synchronous and active-low: rst_n sampled low at a clk_2 rising edge resets all state.
- Reset values: state=HALT, halted=1, cpu_en=0, instr_count=0, synchronizers=0, debounced level=0, debounce count=0, first=0.
- cpu_en is forced to 0 combinationally while rst_n=0, including mid-RUN.
- Synchronization: step_btn and run_sw each pass a 2-flop synchronizer, giving step_s and run_s.
- Debounce (step_s only):
  - The counter increments each cycle step_s != stable and clears when step_s == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 with step_s still != stable, stable takes step_s at the next edge and the counter clears.
  - step_evt = stable & ~stable_prev, a one-cycle pulse.
  - Latency: a held press first sampled at edge N gives step_evt high in cycle N+DEBOUNCE_CYCLES+2, and cpu_en in STEP one cycle later.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
  - A new event requires a debounced release first.
- run_s is used as a level with no debounce.
- bp_hit = bp_en & (pc == bp_addr).
- HALT:
  - cpu_en=0.
  - run_s=1 -> RUN and set first=1.
  - Otherwise step_evt -> STEP.
  - If run_s and step_evt coincide, RUN wins.
- STEP: cpu_en=1 for exactly this one cycle; -> HALT unconditionally. step_evt is ignored here.
- RUN:
  - cpu_en = run_s & ~(bp_hit & ~first).
  - first clears after the first RUN cycle, so a run started at the breakpoint PC leaves it.
  - run_s=0 -> HALT with cpu_en=0 that cycle.
  - Else bp_hit & ~first -> BREAK with cpu_en=0 that cycle; the instruction at bp_addr is not executed.
  - Stop takes priority over breakpoint: run_s=0 and a hit together go to HALT.
  - step_evt is ignored (not queued).
- BREAK:
  - cpu_en=0.
  - run_s=0 -> HALT.
  - Else step_evt -> STEP, which executes the breakpoint instruction.
  - After that STEP the FSM returns to HALT. With run_s still 1 it then immediately re-enters RUN with first=1.
- instr_count: +1 on every cycle with cpu_en=1; wraps 2^NBITS_TOP-1 -> 0. It is not cleared by HALT or BREAK, only by reset.
- halted = (state==HALT) | (state==BREAK), decoded from the registered state.

Test Plan:
- Reset then idle, inputs 0 -> state=0, halted=1, cpu_en=0, instr_count=0 for 20 cycles.
- DEBOUNCE_CYCLES=4: step_btn held high from edge 10 -> exactly one cpu_en pulse, in cycle 17; instr_count=1; state back to 0. A 3-cycle glitch -> no pulse.
- run_sw=1 with bp_en=0 for 300 enabled cycles -> cpu_en continuous; instr_count wraps 255->0 and reads 44; run_sw=0 -> HALT with cpu_en=0 three cycles after the drop.
- pc model incrementing on cpu_en, bp_en=1, bp_addr=0x12, run from pc=0 -> BREAK (state=3) with pc=0x12, cpu_en=0; a debounced step -> single pulse, pc=0x13, state=0 then 2.
- Run started with pc already at 0x12 and bp_en=1 -> the first cycle executes (first flag) and no immediate BREAK.
- rst_n=0 during RUN -> cpu_en=0 in the same cycle; next edge state=0, instr_count=0. Coincident run_s and step_evt in HALT -> RUN.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - board-side and core-side signal bundle for the step controller
interface cpu_step_ctrl_if #(
    parameter int NBITS_TOP = 8
);
    logic                 step_btn;
    logic                 run_sw;
    logic                 bp_en;
    logic [NBITS_TOP-1:0] bp_addr;
    logic [NBITS_TOP-1:0] pc;
    logic                 cpu_en;
    logic                 halted;
    logic [1:0]           state;
    logic [NBITS_TOP-1:0] instr_count;

    modport master (
        output step_btn, run_sw, bp_en, bp_addr, pc,
        input  cpu_en, halted, state, instr_count
    );

    modport slave (
        input  step_btn, run_sw, bp_en, bp_addr, pc,
        output cpu_en, halted, state, instr_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - step/run/breakpoint clock-enable controller with instruction counter
module cpu_step_ctrl #(
    parameter int NBITS_TOP       = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic          clk_2,
    input  logic          rst_n,
    cpu_step_ctrl_if.slave bus
);
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_BREAK = 2'd3;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           step_sync_q, run_sync_q;
    logic                 stable_q, stable_d, stable_prev_q;
    logic [CW-1:0]        db_cnt_q, db_cnt_d;
    logic [1:0]           state_q, state_d;
    logic                 first_q, first_d;
    logic [NBITS_TOP-1:0] count_q, count_d;
    logic                 step_s, run_s, step_evt, bp_hit, en_raw, cpu_en;

    assign step_s   = step_sync_q[1];
    assign run_s    = run_sync_q[1];
    assign step_evt = stable_q & ~stable_prev_q;
    assign bp_hit   = bus.bp_en & (bus.pc == bus.bp_addr);

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (step_s != stable_q) begin
            if (db_cnt_q == DB_LIM) begin
                stable_d = step_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        en_raw  = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_s) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                en_raw  = 1'b1;
                state_d = ST_HALT;
            end
            ST_RUN: begin
                // first lets a run that starts on the breakpoint PC move off it.
                first_d = 1'b0;
                en_raw  = run_s & ~(bp_hit & ~first_q);
                if (!run_s) begin
                    state_d = ST_HALT;
                end else if (bp_hit && !first_q) begin
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (!run_s) begin
                    state_d = ST_HALT;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign cpu_en  = en_raw & rst_n;
    assign count_d = count_q + {{(NBITS_TOP-1){1'b0}}, cpu_en};

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            step_sync_q   <= 2'b00;
            run_sync_q    <= 2'b00;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_HALT;
            first_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            step_sync_q   <= {step_sync_q[0], bus.step_btn};
            run_sync_q    <= {run_sync_q[0], bus.run_sw};
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            first_q       <= first_d;
            count_q       <= count_d;
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == ST_HALT) | (state_q == ST_BREAK);
    assign bus.instr_count = count_q;
endmodule
